inst_prefetch_queue: RTL and testbench

Instruction fetch front-end feeding the decode stage. Holds an internally loadable instruction ROM, a program counter and a small prefetch FIFO. Presents one 8-bit instruction per cycle with its address under a valid/ready handshake, so decode can stall without losing instructions. Supports a flush/redirect for restarting at any address.

---
 rtl/inst_prefetch_if.sv | 23 ++
 rtl/inst_prefetch_queue.sv | 106 ++++++++++
 tb/tb_inst_prefetch_queue.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/inst_prefetch_if.sv
// Decode-side handshake of the instruction prefetch queue: head instruction, its address, valid/ready.
interface inst_prefetch_if #(
    parameter int ADDR_W = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        inst;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output out_valid,
        output inst,
        output inst_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  inst,
        input  inst_pc,
        output out_ready
    );
endinterface

// File: rtl/inst_prefetch_queue.sv
// Instruction fetch front-end: loadable ROM, PC and DEPTH-entry prefetch FIFO feeding decode.
// Latency: ROM[pc] pushed at an enabled edge is presented at the head right after that edge.
// Backpressure: out_ready low lets the FIFO fill to DEPTH, then the PC holds. FETCH_WRAP_EN wraps PC.
module inst_prefetch_queue #(
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   load_en,
    input  logic [ADDR_W-1:0]      load_addr,
    input  logic [7:0]             load_data,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      flush_pc,
    inst_prefetch_if.master        fetch,
    output logic [$clog2(DEPTH):0] count,
    output logic                   done
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [7:0]        inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [7:0]        rom [2**ADDR_W];
    entry_t            q   [DEPTH];
    entry_t            head;
    logic [ADDR_W-1:0] pc;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              exhausted;
    logic              push;
    logic              pop;

    // out_valid decodes registered count only, so out_ready never reaches it.
    assign fetch.out_valid = (count != '0);
    assign pop             = fetch.out_valid & fetch.out_ready;
    assign push            = en & ~exhausted & ((count != FULL) | pop);

    assign head          = q[rd_ptr];
    assign fetch.inst    = fetch.out_valid ? head.inst : 8'h00;
    assign fetch.inst_pc = fetch.out_valid ? head.pc   : '0;

    // ROM has no reset; a same-edge fetch of load_addr sees the previous byte.
    always_ff @(posedge clk) begin
        if (load_en) begin
            rom[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && !flush && push) begin
            q[wr_ptr] <= '{inst: rom[pc], pc: pc};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc     <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            pc     <= flush_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
                pc     <= pc + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef FETCH_WRAP_EN
    assign exhausted = 1'b0;
    assign done      = 1'b0;
`else
    localparam logic [ADDR_W-1:0] LAST_PC = '1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            exhausted <= 1'b0;
        end else if (flush) begin
            exhausted <= 1'b0;
        end else if (push && (pc == LAST_PC)) begin
            exhausted <= 1'b1;
        end
    end

    assign done = exhausted & (count == '0);
`endif
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Directed bench for inst_prefetch_queue (ADDR_W=4, DEPTH=4); end-of-ROM checks follow FETCH_WRAP_EN.
module tb_inst_prefetch_queue;
    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       load_en;
    logic [3:0] load_addr;
    logic [7:0] load_data;
    logic       flush;
    logic [3:0] flush_pc;
    logic [2:0] count;
    logic       done;
    logic [7:0] exp_rom [16];
    int         n_checks = 0;
    int         n_fail   = 0;

    inst_prefetch_if #(.ADDR_W(4)) fif ();

    inst_prefetch_queue #(.ADDR_W(4), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .load_en   (load_en),
        .load_addr (load_addr),
        .load_data (load_data),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .fetch     (fif),
        .count     (count),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [3:0] a);
        chk({tag, " valid"}, 32'(fif.out_valid), 32'd1);
        chk({tag, " inst"},  32'(fif.inst),      32'(exp_rom[a]));
        chk({tag, " pc"},    32'(fif.inst_pc),   32'(a));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid"}, 32'(fif.out_valid), 32'd0);
        chk({tag, " inst"},  32'(fif.inst),      32'h00);
        chk({tag, " pc"},    32'(fif.inst_pc),   32'h0);
        chk({tag, " count"}, 32'(count),         32'd0);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        flush = 1'b0; flush_pc = '0; fif.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_rom[i] = (i < 4) ? 8'(8'h11 * (i + 1)) : 8'(8'h80 | i);
        end

        // Load the whole ROM while held in reset
        for (int i = 0; i < 16; i++) begin
            load_en = 1'b1; load_addr = 4'(i); load_data = exp_rom[i];
            tick();
        end
        load_en = 1'b0;
        tick();
        chk_idle("reset");
        chk("reset done", 32'(done), 32'd0);

        // Streaming: head visible one cycle after enable, then one per cycle
        reset = 1'b1; en = 1'b1; fif.out_ready = 1'b1;
        tick();
        chk_head("first", 4'd0);
        chk("first count", 32'(count), 32'd1);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk_head("stream", 4'(k));
        end

        // Backpressure: fill to DEPTH, then drain without gaps or duplicates
        flush = 1'b1; flush_pc = 4'h0; fif.out_ready = 1'b0;
        tick();
        chk_idle("flush0");
        flush = 1'b0;
        repeat (8) tick();
        chk("full count", 32'(count), 32'd4);
        chk_head("full head", 4'd0);
        fif.out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_head("drain", 4'(k));
            chk("drain count", 32'(count), 32'd4);
        end

        // Flush with 3 entries queued, redirect to 0xA
        flush = 1'b1; flush_pc = 4'h0; fif.out_ready = 1'b0;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("three count", 32'(count), 32'd3);
        flush = 1'b1; flush_pc = 4'hA;
        tick();
        chk_idle("flushA");
        flush = 1'b0; fif.out_ready = 1'b1;
        for (int p = 10; p < 16; p++) begin
            tick();
            chk_head("redirect", 4'(p));
        end
        chk("last done", 32'(done), 32'd0);
`ifdef FETCH_WRAP_EN
        tick();
        chk_head("wrap", 4'h0);
        chk("wrap done", 32'(done), 32'd0);
        tick();
        chk_head("wrap2", 4'h1);
        chk("wrap2 done", 32'(done), 32'd0);
`else
        tick();
        chk_idle("exhausted");
        chk("drained done", 32'(done), 32'd1);
        tick();
        chk("hold count", 32'(count), 32'd0);
        chk("hold done", 32'(done), 32'd1);
`endif

        // Reset mid-stream with 3 entries queued; ROM must survive
        flush = 1'b1; flush_pc = 4'h0; fif.out_ready = 1'b0;
        tick();
        flush = 1'b0;
        repeat (3) tick();
        chk("pre-reset count", 32'(count), 32'd3);
        chk("pre-reset done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        chk_idle("midreset");
        chk("midreset done", 32'(done), 32'd0);
        reset = 1'b1; fif.out_ready = 1'b1;
        tick();
        chk_head("restart", 4'd0);
        tick();
        chk_head("restart2", 4'd1);

        // Same-edge ROM write and fetch of address 5: old byte, new byte on refetch
        en = 1'b0; flush = 1'b1; flush_pc = 4'h5; fif.out_ready = 1'b0;
        tick();
        chk_idle("flush5");
        flush = 1'b0; en = 1'b1;
        load_en = 1'b1; load_addr = 4'h5; load_data = 8'hA5;
        tick();
        chk_head("old byte", 4'd5);
        exp_rom[5] = 8'hA5;
        load_en = 1'b0; flush = 1'b1; flush_pc = 4'h5;
        tick();
        flush = 1'b0; fif.out_ready = 1'b1;
        tick();
        chk_head("new byte", 4'd5);

        // en low freezes pushes
        en = 1'b0; fif.out_ready = 1'b0;
        repeat (2) tick();
        chk("frozen count", 32'(count), 32'd1);
        chk_head("frozen head", 4'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
